// File: rtl/vga_pkg.sv
// vga_pkg: shared constants, colour/state types and constant-multiply helper for the tile framebuffer
package vga_pkg;
  localparam int FB_COLS_DEF = 80;
  localparam int FB_ROWS_DEF = 60;
  localparam int TILE_AW = 13;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;
  typedef enum logic {IDLE, CLEAR} fb_state_t;
  // multiply by a constant as a sum of shifted copies, one per set bit of k
  function automatic logic [TILE_AW-1:0] mul_const(input logic [6:0] v, input int k);
    logic [TILE_AW-1:0] acc;
    acc = '0;
    for (int i = 0; i < TILE_AW; i++)
      if (k[i]) acc = acc + (TILE_AW'(v) << i);
    return acc;
  endfunction
endpackage

// File: rtl/fb_ram_dp.sv
// fb_ram_dp: dual-port read-first tile RAM, write/readback port A and pixel read port B (port A read only with VGA_FB_READBACK_EN)
module fb_ram_dp import vga_pkg::*; #(
  parameter int DEPTH = FB_COLS_DEF * FB_ROWS_DEF,
  parameter int AW = TILE_AW,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr_a,
  input  logic [DW-1:0] i_wdata,
`ifdef VGA_FB_READBACK_EN
  output logic [DW-1:0] o_q_a,
`endif
  input  logic [AW-1:0] i_addr_b,
  output logic [DW-1:0] o_q_b
);
  logic [DW-1:0] r_mem [DEPTH];
  // port A: write, and read-first readback when enabled
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr_a] <= i_wdata;
`ifdef VGA_FB_READBACK_EN
    o_q_a <= r_mem[i_addr_a];
`endif
  end
  // port B: pixel read, sees the pre-write value on a same-address collision
  always_ff @(posedge i_clk)
    o_q_b <= r_mem[i_addr_b];
endmodule

// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 8x8-tile RGB332 framebuffer with CPU writes, clear sweep and pixel read path; VGA_FB_READBACK_EN adds a CPU readback port
module vga_fb_reader import vga_pkg::*; #(
  parameter int FB_COLS = FB_COLS_DEF,
  parameter int FB_ROWS = FB_ROWS_DEF
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [9:0]         ROW,
  input  logic [9:0]         COLUMN,
  output logic [2:0]         RED,
  output logic [2:0]         GREEN,
  output logic [1:0]         BLUE,
  input  logic               WR_VALID,
  output logic               WR_READY,
  input  logic [TILE_AW-1:0] WR_ADDR,
  input  logic [7:0]         WR_DATA,
  input  logic               CLR_REQ,
  input  logic [7:0]         CLR_COLOR,
`ifdef VGA_FB_READBACK_EN
  input  logic               RD_VALID,
  input  logic [TILE_AW-1:0] RD_ADDR,
  output logic [7:0]         RD_DATA,
  output logic               RD_DONE,
`endif
  output logic               BUSY
);
  localparam int DEPTH = FB_COLS * FB_ROWS;
  fb_state_t r_state, w_state_nx;
  logic [TILE_AW-1:0] r_cnt, w_cnt_nx, w_addr_a, w_pix_addr;
  logic [7:0] r_color, w_color_nx, w_wdata, w_pix_q;
  logic r_blank, w_we, w_pix_oob;
  rgb332_t w_rgb;
  assign BUSY = r_state == CLEAR;
  assign WR_READY = r_state == IDLE;
  assign w_we = BUSY || (WR_VALID && WR_READY && WR_ADDR < TILE_AW'(DEPTH));
  assign w_wdata = BUSY ? r_color : WR_DATA;
  assign w_pix_addr = mul_const(ROW[9:3], FB_COLS) + TILE_AW'(COLUMN[9:3]);
  assign w_pix_oob = ROW >= 10'(SCREEN_H) || COLUMN >= 10'(SCREEN_W);
  assign w_rgb = r_blank ? '0 : rgb332_t'(w_pix_q);
  assign RED = w_rgb.r;
  assign GREEN = w_rgb.g;
  assign BLUE = w_rgb.b;
`ifdef VGA_FB_READBACK_EN
  logic r_rd_done, r_rd_oob, w_rd_fire;
  logic [7:0] w_q_a;
  assign w_rd_fire = RD_VALID && WR_READY && !WR_VALID;
  assign w_addr_a = BUSY ? r_cnt : WR_VALID ? WR_ADDR : RD_ADDR;
  assign RD_DONE = r_rd_done;
  assign RD_DATA = r_rd_oob ? 8'h00 : w_q_a;
  // readback completion flag and range mask, one cycle behind the accepted read
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_rd_done <= 1'b0;
      r_rd_oob <= 1'b0;
    end else begin
      r_rd_done <= w_rd_fire;
      r_rd_oob <= RD_ADDR >= TILE_AW'(DEPTH);
    end
`else
  assign w_addr_a = BUSY ? r_cnt : WR_ADDR;
`endif
  // next state: a clear request latches its colour, the sweep ends after the last tile
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx = r_cnt;
    w_color_nx = r_color;
    if (r_state == IDLE) begin
      if (CLR_REQ) begin
        w_state_nx = CLEAR;
        w_cnt_nx = '0;
        w_color_nx = CLR_COLOR;
      end
    end else begin
      w_cnt_nx = r_cnt + 1'b1;
      if (r_cnt == TILE_AW'(DEPTH - 1)) begin
        w_state_nx = IDLE;
        w_cnt_nx = '0;
      end
    end
  end
  // state, sweep counter and latched colour; reset starts a black sweep
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      r_state <= CLEAR;
      r_cnt <= '0;
      r_color <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt <= w_cnt_nx;
      r_color <= w_color_nx;
    end
  // off-screen mask aligned with the registered RAM output
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) r_blank <= 1'b1;
    else r_blank <= w_pix_oob;
  fb_ram_dp #(.DEPTH(DEPTH), .AW(TILE_AW), .DW(8)) u_ram (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_addr_a(w_addr_a),
    .i_wdata (w_wdata),
`ifdef VGA_FB_READBACK_EN
    .o_q_a   (w_q_a),
`endif
    .i_addr_b(w_pix_addr),
    .o_q_b   (w_pix_q)
  );
endmodule

// File: tb/tb_vga_fb_reader.sv
// tb_vga_fb_reader: scoreboard bench for vga_fb_reader (optional VGA_FB_READBACK_EN ports)
module tb_vga_fb_reader;
  logic CLK = 1'b0, RST_N = 1'b1;
  logic [9:0] ROW = '0, COLUMN = '0;
  logic [2:0] RED, GREEN;
  logic [1:0] BLUE;
  logic WR_VALID = 1'b0, WR_READY, CLR_REQ = 1'b0, BUSY;
  logic [12:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0, CLR_COLOR = '0;
`ifdef VGA_FB_READBACK_EN
  logic RD_VALID = 1'b0, RD_DONE;
  logic [12:0] RD_ADDR = '0;
  logic [7:0] RD_DATA;
`endif
  int errors = 0, checks = 0;
  logic [7:0] gm [4800];
  logic [7:0] exp_q [$];

  vga_fb_reader dut (
    .CLK(CLK), .RST_N(RST_N), .ROW(ROW), .COLUMN(COLUMN),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
    .CLR_REQ(CLR_REQ), .CLR_COLOR(CLR_COLOR),
`ifdef VGA_FB_READBACK_EN
    .RD_VALID(RD_VALID), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_DONE(RD_DONE),
`endif
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_tile(input int t);
    ROW = 10'((t / 80) * 8 + int'($urandom_range(0, 7)));
    COLUMN = 10'((t % 80) * 8 + int'($urandom_range(0, 7)));
  endtask

  task automatic wr(input logic [12:0] a, input logic [7:0] d);
    int n = 0;
    WR_VALID = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    while (WR_READY !== 1'b1 && n < 10000) begin
      n++;
      cyc();
    end
    if (n == 10000) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout: WR_READY=%b required 1", WR_READY);
    end
    cyc();
    WR_VALID = 1'b0;
    if (a < 13'd4800) gm[a] = d;
  endtask

  task automatic busy_span(input string tag);
    int n = 0;
    while (BUSY === 1'b1 && n < 6000) begin
      n++;
      cyc();
    end
    checks++;
    if (n != 4800) begin
      errors++;
      $display("FAIL %s_busy_span: %0d cycles required 4800", tag, n);
    end
  endtask

  task automatic test_full_sweep(input string tag);
    logic [7:0] e;
    for (int t = 0; t < 4800; t++) begin
      set_tile(t);
      exp_q.push_back(gm[t]);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if ({RED, GREEN, BLUE} !== e) begin
        errors++;
        $display("FAIL %s_tile%0d: rgb=%h required %h", tag, t, {RED, GREEN, BLUE}, e);
      end
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    repeat (3) cyc();
    checks++;
    if ({BUSY, WR_READY} !== 2'b10) begin
      errors++;
      $display("FAIL reset_flags: BUSY,WR_READY=%b required 10", {BUSY, WR_READY});
    end
    checks++;
    if ({RED, GREEN, BLUE} !== 8'h00) begin
      errors++;
      $display("FAIL reset_rgb: rgb=%h required 00", {RED, GREEN, BLUE});
    end
    RST_N = 1'b1;
    busy_span("boot");
    checks++;
    if (WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL boot_ready: WR_READY=%b required 1", WR_READY);
    end
    foreach (gm[i]) gm[i] = 8'h00;
    test_full_sweep("boot");
  endtask

  task automatic test_write_pixel();
    logic [7:0] e;
    int rc [2] = '{8, 15};
    wr(13'd81, 8'hE3);
    for (int i = 0; i < 2; i++) begin
      ROW = 10'(rc[i]);
      COLUMN = 10'(rc[i]);
      exp_q.push_back(8'hE3);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if ({RED, GREEN, BLUE} !== e) begin
        errors++;
        $display("FAIL pix_%0d_%0d: R=%0d G=%0d B=%0d required R=7 G=0 B=3", rc[i], rc[i], RED, GREEN, BLUE);
      end
    end
    WR_VALID = 1'b1;
    WR_ADDR = 13'd81;
    WR_DATA = 8'h55;
    ROW = 10'd9;
    COLUMN = 10'd12;
    exp_q.push_back(gm[81]);
    cyc();
    WR_VALID = 1'b0;
    gm[81] = 8'h55;
    e = exp_q.pop_front();
    checks++;
    if ({RED, GREEN, BLUE} !== e) begin
      errors++;
      $display("FAIL read_first: rgb=%h required %h", {RED, GREEN, BLUE}, e);
    end
    exp_q.push_back(gm[81]);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if ({RED, GREEN, BLUE} !== e) begin
      errors++;
      $display("FAIL read_after_write: rgb=%h required %h", {RED, GREEN, BLUE}, e);
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] e;
    int rs [6] = '{480, 100, 479, 1023, 0, 479};
    int cs [6] = '{100, 640, 639, 1023, 0, 640};
    wr(13'd4799, 8'h92);
    wr(13'd4812 - 13'd4800, 8'hFF);
    for (int i = 0; i < 6; i++) begin
      ROW = 10'(rs[i]);
      COLUMN = 10'(cs[i]);
      exp_q.push_back((rs[i] >= 480 || cs[i] >= 640) ? 8'h00 : gm[(rs[i] / 8) * 80 + cs[i] / 8]);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if ({RED, GREEN, BLUE} !== e) begin
        errors++;
        $display("FAIL range_r%0d_c%0d: rgb=%h required %h", rs[i], cs[i], {RED, GREEN, BLUE}, e);
      end
    end
  endtask

  task automatic test_oob_write();
    logic [12:0] as [2] = '{13'd4800, 13'd8191};
    for (int i = 0; i < 2; i++) begin
      WR_VALID = 1'b1;
      WR_ADDR = as[i];
      WR_DATA = 8'hAA;
      checks++;
      if (WR_READY !== 1'b1) begin
        errors++;
        $display("FAIL oob_accept_%0d: WR_READY=%b required 1", as[i], WR_READY);
      end
      cyc();
    end
    WR_VALID = 1'b0;
    test_full_sweep("oob_write");
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    int ad [16];
    for (int i = 0; i < 16; i++) begin
      ad[i] = int'($urandom_range(0, 4799));
      WR_VALID = 1'b1;
      WR_ADDR = 13'(ad[i]);
      WR_DATA = 8'($urandom);
      checks++;
      if (WR_READY !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: WR_READY=%b required 1", i, WR_READY);
      end
      cyc();
      gm[ad[i]] = WR_DATA;
    end
    WR_VALID = 1'b0;
    for (int i = 0; i < 16; i++) begin
      set_tile(ad[i]);
      exp_q.push_back(gm[ad[i]]);
      cyc();
      e = exp_q.pop_front();
      checks++;
      if ({RED, GREEN, BLUE} !== e) begin
        errors++;
        $display("FAIL b2b_tile%0d: rgb=%h required %h", ad[i], {RED, GREEN, BLUE}, e);
      end
    end
  endtask

`ifdef VGA_FB_READBACK_EN
  task automatic test_readback();
    RD_VALID = 1'b1;
    RD_ADDR = 13'd81;
    wr(13'd100, 8'h33);
    checks++;
    if (RD_DONE !== 1'b0) begin
      errors++;
      $display("FAIL rd_write_priority: RD_DONE=%b required 0", RD_DONE);
    end
    cyc();
    RD_ADDR = 13'd5000;
    checks++;
    if ({RD_DONE, RD_DATA} !== {1'b1, gm[81]}) begin
      errors++;
      $display("FAIL rd_data: done,data=%b,%h required 1,%h", RD_DONE, RD_DATA, gm[81]);
    end
    cyc();
    RD_VALID = 1'b0;
    checks++;
    if ({RD_DONE, RD_DATA} !== 9'h100) begin
      errors++;
      $display("FAIL rd_oob: done,data=%b,%h required 1,00", RD_DONE, RD_DATA);
    end
  endtask
`endif

  task automatic test_clear_collision();
    logic [7:0] e;
    int n = 0;
    WR_VALID = 1'b1;
    WR_ADDR = 13'd5;
    WR_DATA = 8'hFF;
    CLR_REQ = 1'b1;
    CLR_COLOR = 8'h1C;
    cyc();
    WR_VALID = 1'b0;
    CLR_REQ = 1'b0;
    while (BUSY === 1'b1 && n < 6000) begin
      checks++;
      if (WR_READY !== 1'b0) begin
        errors++;
        $display("FAIL clear_ready_%0d: WR_READY=%b required 0", n, WR_READY);
      end
      n++;
      if (n == 200) begin
        set_tile(10);
        exp_q.push_back(8'h1C);
      end
      if (n == 201 || n == 202) begin
        e = exp_q.pop_front();
        checks++;
        if ({RED, GREEN, BLUE} !== e) begin
          errors++;
          $display("FAIL clear_partial_%0d: rgb=%h required %h", n, {RED, GREEN, BLUE}, e);
        end
      end
      if (n == 201) begin
        set_tile(4799);
        exp_q.push_back(gm[4799]);
        CLR_REQ = 1'b1;
        CLR_COLOR = 8'hE0;
      end
      if (n == 202) CLR_REQ = 1'b0;
      cyc();
    end
    checks++;
    if (n != 4800) begin
      errors++;
      $display("FAIL clear_busy_span: %0d cycles required 4800", n);
    end
    foreach (gm[i]) gm[i] = 8'h1C;
    ROW = 10'd0;
    COLUMN = 10'd40;
    exp_q.push_back(8'h1C);
    cyc();
    e = exp_q.pop_front();
    checks++;
    if ({RED, GREEN, BLUE} !== e) begin
      errors++;
      $display("FAIL clear_wins_addr5: rgb=%h required %h", {RED, GREEN, BLUE}, e);
    end
    test_full_sweep("clear");
  endtask

  task automatic test_reset_mid_sweep();
    wr(13'd3000, 8'h77);
    CLR_REQ = 1'b1;
    CLR_COLOR = 8'hFF;
    cyc();
    CLR_REQ = 1'b0;
    repeat (2000) cyc();
    RST_N = 1'b0;
    #1;
    checks++;
    if ({BUSY, WR_READY, RED, GREEN, BLUE} !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL midreset_outputs: BUSY,WR_READY,rgb=%b,%b,%h required 1,0,00", BUSY, WR_READY, {RED, GREEN, BLUE});
    end
    repeat (2) cyc();
    RST_N = 1'b1;
    busy_span("midreset");
    foreach (gm[i]) gm[i] = 8'h00;
    test_full_sweep("midreset");
  endtask

  initial begin
    test_reset();
    test_write_pixel();
    test_out_of_range();
    test_oob_write();
    test_back_to_back();
`ifdef VGA_FB_READBACK_EN
    test_readback();
`endif
    test_clear_collision();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/vga_fb_reader.md
VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter FB_COLS, default 80, meaning tile columns (640/8).
REQ-002 SHALL have parameter FB_ROWS, default 60, meaning tile rows (480/8).
REQ-003 SHALL have port CLK  input  1  single pixel clock, 25 MHz.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ROW  input  10  pixel row from the VGA driver.
REQ-006 SHALL have port COLUMN  input  10  pixel column from the VGA driver.
REQ-007 SHALL have port RED  output  3  pixel red to the driver.
REQ-008 SHALL have port GREEN  output  3  pixel green to the driver.
REQ-009 SHALL have port BLUE  output  2  pixel blue to the driver.
REQ-010 SHALL have port WR_VALID  input  1  CPU tile write request.
REQ-011 SHALL have port WR_READY  output  1  write accepted this cycle.
REQ-012 SHALL have port WR_ADDR  input  13  tile index, row*FB_COLS+col.
REQ-013 SHALL have port WR_DATA  input  8  tile colour, RGB332 {R[2:0],G[2:0],B[1:0]}.
REQ-014 SHALL have port CLR_REQ  input  1  one-cycle pulse that starts a clear-screen sweep.
REQ-015 SHALL have port CLR_COLOR  input  8  clear colour, sampled with CLR_REQ.
REQ-016 SHALL have port BUSY  output  1  a clear sweep is in progress.

Function
REQ-017 SHALL hold FB_COLS*FB_ROWS x 8-bit tile storage, with one CPU/clear port and one independent pixel read port.
REQ-018 Pixel address SHALL be (ROW>>3)*FB_COLS + (COLUMN>>3); the multiply SHALL be done as shifts and adds, 13-bit result.
REQ-019 RED/GREEN/BLUE SHALL be registered and valid exactly 1 cycle after ROW/COLUMN are presented.
REQ-020 ROW>=480 or COLUMN>=640 SHALL produce 0 on RED/GREEN/BLUE on that output cycle.
REQ-021 Writes SHALL use a valid/ready handshake: a write commits when WR_VALID&&WR_READY at a CLK edge.
REQ-022 WR_READY SHALL be 1 in IDLE and 0 in CLEAR.
REQ-023 A write with WR_ADDR>=FB_COLS*FB_ROWS SHALL be accepted and discarded.
REQ-024 A same-address pixel read and write in the same cycle SHALL return the old data (read-first).
REQ-025 The FSM SHALL have states IDLE and CLEAR.
REQ-026 IDLE->CLEAR on CLR_REQ: latch CLR_COLOR, set the sweep counter to 0, set BUSY=1 on the next cycle.
REQ-027 In CLEAR, SHALL write the latched colour to the counter address once per cycle and increment the counter.
REQ-028 CLEAR->IDLE after address FB_COLS*FB_ROWS-1 is written, i.e. exactly 4800 cycles by default; BUSY SHALL drop on the following cycle.
REQ-029 CLR_REQ during CLEAR SHALL be ignored.
REQ-030 CLR_REQ and WR_VALID in the same IDLE cycle: the write SHALL commit first, then the sweep SHALL overwrite it.
REQ-031 The pixel read path SHALL keep operating during CLEAR; it shows partially cleared content.

Reset
REQ-032 While RST_N=0: RED/GREEN/BLUE=0, FSM=CLEAR, counter=0, latched colour=0x00, BUSY=1, WR_READY=0.
REQ-033 Release of reset SHALL start an automatic clear to black (4800 cycles).
REQ-034 Reset asserted mid-sweep SHALL restart the sweep from 0 with colour 0x00.
REQ-035 Storage contents SHALL NOT be reset directly; they are defined only by the sweep.

Configuration
REQ-036 Macro VGA_FB_READBACK_EN defined: add ports RD_VALID (in, 1), RD_ADDR (in, 13), RD_DATA (out, 8) and RD_DONE (out, 1).
REQ-037 With the macro, RD_DATA/RD_DONE SHALL follow an accepted read by 1 cycle; reads share WR_READY.
REQ-038 With the macro, simultaneous RD_VALID and WR_VALID SHALL give the write priority; the read SHALL stay pending until accepted.
REQ-039 With the macro, an out-of-range read SHALL return 0x00.
REQ-040 Without the macro, these ports and their logic SHALL be absent.

Structure
REQ-041 Package vga_pkg SHALL hold FB_COLS/FB_ROWS defaults, the tile address width (13), the RGB332 field typedef, the FSM state enum {IDLE, CLEAR}, and the screen limits 640/480.
REQ-042 Storage SHALL be a sub-module fb_ram_dp: dual port, read-first, 1-cycle read, inferable as BRAM.

Verification
REQ-043 Reset release: BUSY=1 for 4800 cycles, then 0; every tile reads 0x00 and WR_READY=1.
REQ-044 Write addr 81 = 0xE3, then ROW=8, COLUMN=8: next cycle RED=7, GREEN=0, BLUE=3; ROW=15, COLUMN=15 gives the same.
REQ-045 ROW=480, COLUMN=100 -> RGB=0 one cycle later, regardless of storage contents.
REQ-046 CLR_REQ with CLR_COLOR=0x1C while WR_VALID=1 at addr 5 = 0xFF: after the sweep, addr 5 reads 0x1C; WR_READY=0 throughout the sweep.
REQ-047 RST_N pulsed low at sweep count 2000 -> sweep restarts at 0 with colour 0x00; BUSY spans 4800 cycles after release.
REQ-048 Write to addr 4800 -> accepted; no tile changes (pixel sweep compares to golden model).
